// File: rtl/otter_pkg.sv
// Shared types for the OTTER multicycle control path: opcodes, PC source
// selects, sequencer states and branch FUNC3 encodings.
package otter_pkg;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011,
    OPC_SYSTEM = 7'b1110011
  } opcode_t;

  typedef enum logic [2:0] {
    PCS_PC4,
    PCS_JALR,
    PCS_JAL,
    PCS_BRANCH,
    PCS_MTVEC,
    PCS_MEPC
  } pc_src_t;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_EXEC,
    ST_WB,
    ST_INTR
  } seq_state_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/branch_cond_gen.sv
// Branch condition resolver: FUNC3 plus comparator flags -> branch taken.
// FUNC3 values 010/011 are reserved and never taken.
module branch_cond_gen
  import otter_pkg::*;
(
  input  logic [2:0] func3_i,
  input  logic       br_eq_i,
  input  logic       br_lt_i,
  input  logic       br_ltu_i,
  output logic       taken_o
);

  // Select the comparator flag (or its inverse) named by FUNC3.
  always_comb begin
    taken_o = 1'b0;
    case (func3_i)
      F3_BEQ:  taken_o = br_eq_i;
      F3_BNE:  taken_o = ~br_eq_i;
      F3_BLT:  taken_o = br_lt_i;
      F3_BGE:  taken_o = ~br_lt_i;
      F3_BLTU: taken_o = br_ltu_i;
      F3_BGEU: taken_o = ~br_ltu_i;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// OTTER multicycle control sequencer: PC register, next-PC mux and the
// FETCH/EXEC/WB/INTR state machine with memory/register-file strobes.
// Optional feature macro: PC_SEQ_INTR_EN (interrupt entry via INTR state).
module pc_sequencer
  import otter_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [6:0]  OPCODE,
  input  logic [2:0]  FUNC3,
  input  logic        BR_EQ,
  input  logic        BR_LT,
  input  logic        BR_LTU,
  input  logic [31:0] JALR_ADDR,
  input  logic [31:0] JAL_ADDR,
  input  logic [31:0] BRANCH_ADDR,
  input  logic [31:0] MTVEC,
  input  logic [31:0] MEPC,
  input  logic        INTR,
  input  logic        MIE,
  output logic [31:0] PC,
  output logic [31:0] NEXT_PC,
  output logic        MEM_RDEN1,
  output logic        MEM_RDEN2,
  output logic        MEM_WE2,
  output logic        REG_WE,
  output logic        INT_TAKEN
);

  seq_state_t  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  pc_src_t     pc_src;
  logic [31:0] insn_next_pc;
  logic        br_taken;
  logic        intr_req;

  branch_cond_gen u_branch_cond_gen (
    .func3_i  (FUNC3),
    .br_eq_i  (BR_EQ),
    .br_lt_i  (BR_LT),
    .br_ltu_i (BR_LTU),
    .taken_o  (br_taken)
  );

`ifdef PC_SEQ_INTR_EN
  assign intr_req = INTR & MIE;
  logic unused_jalr_lsb;
  assign unused_jalr_lsb = JALR_ADDR[0];
`else
  assign intr_req = 1'b0;
  logic unused_intr_inputs;
  assign unused_intr_inputs = ^{INTR, MIE, MTVEC, JALR_ADDR[0]};
`endif

  // Pick the PC source for the instruction currently held in the IR.
  always_comb begin
    pc_src = PCS_PC4;
    case (OPCODE)
      OPC_JAL:    pc_src = PCS_JAL;
      OPC_JALR:   pc_src = PCS_JALR;
      OPC_SYSTEM: pc_src = (FUNC3 == 3'b000) ? PCS_MEPC : PCS_PC4;
      OPC_BRANCH: pc_src = br_taken ? PCS_BRANCH : PCS_PC4;
      default:    pc_src = PCS_PC4;
    endcase
  end

  // Next-PC mux; PC+4 naturally wraps modulo 2^32.
  always_comb begin
    insn_next_pc = pc_q + 32'd4;
    case (pc_src)
      PCS_JAL:    insn_next_pc = JAL_ADDR;
      PCS_JALR:   insn_next_pc = {JALR_ADDR[31:1], 1'b0};
      PCS_BRANCH: insn_next_pc = BRANCH_ADDR;
      PCS_MEPC:   insn_next_pc = MEPC;
      PCS_MTVEC:  insn_next_pc = MTVEC;
      default:    insn_next_pc = pc_q + 32'd4;
    endcase
  end

  // In INTR the PC has already advanced, so it is the MEPC save value.
  assign NEXT_PC = (state_q == ST_INTR) ? pc_q : insn_next_pc;
  assign PC      = pc_q;

  // State and PC registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_VEC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next state and PC update; interrupts are sampled only at EXEC/WB exit.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC: begin
        if (OPCODE == OPC_LOAD) begin
          state_d = ST_WB;
        end else begin
          pc_d    = insn_next_pc;
          state_d = intr_req ? ST_INTR : ST_FETCH;
        end
      end
      ST_WB: begin
        pc_d    = insn_next_pc;
        state_d = intr_req ? ST_INTR : ST_FETCH;
      end
      ST_INTR: begin
        pc_d    = MTVEC;
        state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // Strobes per state; all forced low while reset is asserted.
  always_comb begin
    MEM_RDEN1 = 1'b0;
    MEM_RDEN2 = 1'b0;
    MEM_WE2   = 1'b0;
    REG_WE    = 1'b0;
    INT_TAKEN = 1'b0;
    if (!RST) begin
      case (state_q)
        ST_FETCH: MEM_RDEN1 = 1'b1;
        ST_EXEC: begin
          case (OPCODE)
            OPC_LOAD:   MEM_RDEN2 = 1'b1;
            OPC_STORE:  MEM_WE2   = 1'b1;
            OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR:
                        REG_WE    = 1'b1;
            OPC_SYSTEM: REG_WE    = (FUNC3 != 3'b000);
            default:    REG_WE    = 1'b0;
          endcase
        end
        ST_WB:   REG_WE = 1'b1;
`ifdef PC_SEQ_INTR_EN
        ST_INTR: INT_TAKEN = 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule
